// File: rtl/fir_decimator.sv
// Integrate-and-dump decimator: averages blocks of 2^LOG2D valid samples and
// hands each average to the sink through a 2-entry valid/ready output buffer.
module fir_decimator #(
  parameter int M     = 8,
  parameter int LOG2D = 3
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic signed [M-1:0]                 x,
  input  logic                                in_valid,
  input  logic                                flush,
  output logic signed [M-1:0]                 y,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                overflow,
  output logic [((LOG2D < 1) ? 1 : LOG2D)-1:0] phase
);

  localparam int AW = M + LOG2D;
  localparam int PW = (LOG2D < 1) ? 1 : LOG2D;
  localparam logic [PW-1:0] LAST = PW'((1 << LOG2D) - 1);

  logic signed [AW-1:0] acc_q, acc_d;
  logic [PW-1:0]        cnt_q, cnt_d;
  logic signed [AW-1:0] sum;
  logic signed [M-1:0]  result;
  logic                 push;
  logic                 pop;

  logic signed [M-1:0]  head_q, head_d;
  logic                 head_vld_q, head_vld_d;
  logic signed [M-1:0]  tail_q, tail_d;
  logic                 tail_vld_q, tail_vld_d;
  logic                 ovf_q, ovf_d;

  // The upper M bits of the full block sum are the floor-divided average.
  always_comb begin
    sum    = acc_q + AW'(x);
    result = sum[AW-1:LOG2D];
    push   = 1'b0;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    if (flush) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (in_valid) begin
      if (cnt_q == LAST) begin
        push  = 1'b1;
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + PW'(1);
      end
    end
  end

  always_comb begin
    pop        = head_vld_q & out_ready;
    head_d     = head_q;
    head_vld_d = head_vld_q;
    tail_d     = tail_q;
    tail_vld_d = tail_vld_q;
    ovf_d      = ovf_q;
    if (pop) begin
      if (tail_vld_q) begin
        head_d     = tail_q;
        head_vld_d = 1'b1;
        tail_vld_d = push;
        if (push) tail_d = result;
      end else begin
        head_vld_d = push;
        if (push) head_d = result;
      end
    end else if (push) begin
      if (!head_vld_q) begin
        head_d     = result;
        head_vld_d = 1'b1;
      end else if (!tail_vld_q) begin
        tail_d     = result;
        tail_vld_d = 1'b1;
      end else begin
        // Both slots taken and nothing leaving: the new result is lost.
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      head_q     <= '0;
      head_vld_q <= 1'b0;
      tail_q     <= '0;
      tail_vld_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      head_q     <= head_d;
      head_vld_q <= head_vld_d;
      tail_q     <= tail_d;
      tail_vld_q <= tail_vld_d;
      ovf_q      <= ovf_d;
    end
  end

  assign y         = head_q;
  assign out_valid = head_vld_q;
  assign overflow  = ovf_q;
  assign phase     = cnt_q;

endmodule

// File: tb/tb_fir_decimator.sv
// Directed bench for fir_decimator: a queue-based block-average model checked
// every cycle, plus literal expectations for each scenario.
module tb_fir_decimator;

  localparam int M     = 8;
  localparam int LOG2D = 3;
  localparam int D     = 1 << LOG2D;

  logic                clk;
  logic                resetIn;
  logic signed [M-1:0] xIn;
  logic                validIn;
  logic                flushIn;
  logic signed [M-1:0] y;
  logic                out_valid;
  logic                readyIn;
  logic                overflow;
  logic [LOG2D-1:0]    phase;

  int checks   = 0;
  int failures = 0;
  bit compareEn = 0;

  int mSum;
  int mCnt;
  int mFifo[$];
  int mLastY;
  bit mOvf;

  fir_decimator #(.M(M), .LOG2D(LOG2D)) dut (
    .clk(clk),
    .reset(resetIn),
    .x(xIn),
    .in_valid(validIn),
    .flush(flushIn),
    .y(y),
    .out_valid(out_valid),
    .out_ready(readyIn),
    .overflow(overflow),
    .phase(phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int xv, input bit v, input bit f);
    xIn     = M'(xv);
    validIn = v;
    flushIn = f;
    @(posedge clk);
    #1;
  endtask

  task automatic runBlock(input int value);
    for (int i = 0; i < D; i++) applyStimulus(value, 1'b1, 1'b0);
  endtask

  // Reference: keep a running block sum and a bounded FIFO of averages.
  always @(posedge clk) begin
    if (resetIn) begin
      mSum = 0;
      mCnt = 0;
      mFifo.delete();
      mLastY = 0;
      mOvf = 0;
    end else begin
      bit pushNow;
      int res;
      pushNow = 0;
      res = 0;
      if (flushIn) begin
        mSum = 0;
        mCnt = 0;
      end else if (validIn) begin
        mSum += int'(xIn);
        mCnt++;
        if (mCnt == D) begin
          res = mSum >>> LOG2D;
          pushNow = 1;
          mSum = 0;
          mCnt = 0;
        end
      end
      if (mFifo.size() > 0 && readyIn) mLastY = mFifo.pop_front();
      if (pushNow) begin
        if (mFifo.size() < 2) mFifo.push_back(res);
        else mOvf = 1;
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (compareEn) begin
      checkOutput("cmp_out_valid", int'(out_valid), (mFifo.size() > 0) ? 1 : 0);
      checkOutput("cmp_y", int'(y), (mFifo.size() > 0) ? mFifo[0] : mLastY);
      checkOutput("cmp_overflow", int'(overflow), int'(mOvf));
      checkOutput("cmp_phase", int'(phase), mCnt);
    end
  end

  initial begin
    resetIn = 1'b1;
    readyIn = 1'b1;
    xIn     = '0;
    validIn = 1'b0;
    flushIn = 1'b0;
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("reset_out_valid", int'(out_valid), 0);
    checkOutput("reset_y", int'(y), 0);
    checkOutput("reset_overflow", int'(overflow), 0);
    checkOutput("reset_phase", int'(phase), 0);
    resetIn = 1'b0;
    compareEn = 1'b1;

    for (int i = 1; i <= D; i++) begin
      applyStimulus(16, 1, 0);
      checkOutput("ramp_phase", int'(phase), i % D);
      if (i < D) checkOutput("ramp_no_output", int'(out_valid), 0);
    end
    checkOutput("block16_valid", int'(out_valid), 1);
    checkOutput("block16_y", int'(y), 16);
    applyStimulus(0, 0, 0);
    checkOutput("block16_one_cycle", int'(out_valid), 0);

    for (int i = 1; i <= D; i++) applyStimulus(i, 1, 0);
    checkOutput("ramp_avg_y", int'(y), 4);
    applyStimulus(0, 0, 0);
    runBlock(-1);
    checkOutput("minus1_y", int'(y), -1);
    applyStimulus(0, 0, 0);
    runBlock(127);
    checkOutput("max_y", int'(y), 127);
    applyStimulus(0, 0, 0);
    runBlock(-128);
    checkOutput("min_y", int'(y), -128);
    applyStimulus(0, 0, 0);

    for (int i = 0; i < 2 * D; i++) begin
      if (i % 2 == 0) applyStimulus(10, 1, 0);
      else applyStimulus(99, 0, 0);
      if (i == 2 * D - 3) checkOutput("gapped_not_yet", int'(out_valid), 0);
      if (i == 2 * D - 2) begin
        checkOutput("gapped_valid", int'(out_valid), 1);
        checkOutput("gapped_y", int'(y), 10);
      end
      if (i == 2 * D - 1) checkOutput("gapped_phase_hold", int'(phase), 0);
    end

    readyIn = 1'b0;
    runBlock(5);
    runBlock(6);
    runBlock(7);
    checkOutput("stall_valid", int'(out_valid), 1);
    checkOutput("stall_y", int'(y), 5);
    checkOutput("stall_overflow", int'(overflow), 1);
    readyIn = 1'b1;
    applyStimulus(0, 0, 0);
    checkOutput("drain_y6", int'(y), 6);
    checkOutput("drain_valid6", int'(out_valid), 1);
    applyStimulus(0, 0, 0);
    checkOutput("drain_empty", int'(out_valid), 0);
    checkOutput("drain_y_hold", int'(y), 6);
    checkOutput("drain_overflow_sticky", int'(overflow), 1);

    for (int i = 0; i < 4; i++) applyStimulus(100, 1, 0);
    applyStimulus(50, 1, 1);
    checkOutput("flush_phase", int'(phase), 0);
    checkOutput("flush_no_output", int'(out_valid), 0);
    runBlock(8);
    checkOutput("after_flush_y", int'(y), 8);
    applyStimulus(0, 0, 0);

    readyIn = 1'b0;
    runBlock(20);
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, 0);
    checkOutput("prereset_phase", int'(phase), 5);
    checkOutput("prereset_valid", int'(out_valid), 1);
    resetIn = 1'b1;
    applyStimulus(1, 1, 0);
    resetIn = 1'b0;
    checkOutput("midreset_valid", int'(out_valid), 0);
    checkOutput("midreset_overflow", int'(overflow), 0);
    checkOutput("midreset_phase", int'(phase), 0);
    readyIn = 1'b1;
    runBlock(-3);
    checkOutput("minus3_y", int'(y), -3);
    applyStimulus(0, 0, 0);

    readyIn = 1'b0;
    runBlock(2);
    runBlock(3);
    for (int i = 0; i < D - 1; i++) applyStimulus(4, 1, 0);
    readyIn = 1'b1;
    applyStimulus(4, 1, 0);
    checkOutput("full_pushpop_y", int'(y), 3);
    checkOutput("full_pushpop_overflow", int'(overflow), 0);
    applyStimulus(0, 0, 0);
    checkOutput("full_pushpop_next", int'(y), 4);
    applyStimulus(0, 0, 0);
    checkOutput("full_pushpop_empty", int'(out_valid), 0);

    applyStimulus(0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
